// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - state, instruction-class, opcode and ALU code definitions for control_sequencer
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT, S_WAIT_STEP
  } state_t;

  typedef enum logic [2:0] {
    CL_RRR, CL_IMM, CL_UNARY, CL_MULDIV, CL_NOP, CL_HALT, CL_ILL
  } op_class_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_NEG  = 5'b01001;
  localparam logic [4:0] OP_NOT  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01100;
  localparam logic [4:0] OP_ADDI = 5'b01101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NOP = 5'd0;
  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_AND = 5'd3;
  localparam logic [4:0] ALU_OR  = 5'd4;
  localparam logic [4:0] ALU_SHR = 5'd5;
  localparam logic [4:0] ALU_SHL = 5'd6;
  localparam logic [4:0] ALU_NEG = 5'd7;
  localparam logic [4:0] ALU_NOT = 5'd8;
  localparam logic [4:0] ALU_MUL = 5'd9;
  localparam logic [4:0] ALU_DIV = 5'd10;

endpackage

// File: rtl/control_sequencer_op_class.sv
// rtl/control_sequencer_op_class.sv - combinational opcode to instruction class and ALU operation decode
module control_sequencer_op_class
  import control_sequencer_pkg::*;
(
  input  logic [4:0] i_opcode,
  output logic [2:0] o_class,
  output logic [4:0] o_alu_op
);

  op_class_t w_class;

  always_comb begin
    w_class  = CL_ILL;
    o_alu_op = ALU_NOP;
    case (i_opcode)
      OP_ADD:  begin w_class = CL_RRR;    o_alu_op = ALU_ADD; end
      OP_SUB:  begin w_class = CL_RRR;    o_alu_op = ALU_SUB; end
      OP_AND:  begin w_class = CL_RRR;    o_alu_op = ALU_AND; end
      OP_OR:   begin w_class = CL_RRR;    o_alu_op = ALU_OR;  end
      OP_SHR:  begin w_class = CL_RRR;    o_alu_op = ALU_SHR; end
      OP_SHL:  begin w_class = CL_RRR;    o_alu_op = ALU_SHL; end
      OP_ADDI: begin w_class = CL_IMM;    o_alu_op = ALU_ADD; end
      OP_NEG:  begin w_class = CL_UNARY;  o_alu_op = ALU_NEG; end
      OP_NOT:  begin w_class = CL_UNARY;  o_alu_op = ALU_NOT; end
      OP_MUL:  begin w_class = CL_MULDIV; o_alu_op = ALU_MUL; end
      OP_DIV:  begin w_class = CL_MULDIV; o_alu_op = ALU_DIV; end
      OP_NOP:  w_class = CL_NOP;
      OP_HALT: w_class = CL_HALT;
      default: ;
    endcase
  end

  assign o_class = w_class;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Mini SRC fetch/execute control FSM; CTRL_STEP_EN adds a Step input for single-instruction stepping
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OP_W       = 5,
  parameter int WAIT_LIMIT = 15
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        MemReady,
`ifdef CTRL_STEP_EN
  input  logic        Step,
`endif
  output logic        PCout,
  output logic        ZHighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        IncPC,
  output logic        Read,
  output logic [4:0]  AluOp,
  output logic        Run,
  output logic        IllegalOp,
  output logic        BusErr
);

  localparam logic [7:0] LP_WAIT_LIMIT = 8'(WAIT_LIMIT);

  state_t          r_state, w_state_nxt, w_done_state;
  logic [7:0]      r_wait_cnt, w_wait_cnt_nxt;
  logic            r_bus_err, w_bus_err_nxt;
  logic [OP_W-1:0] w_opcode;
  logic [2:0]      w_class_bits;
  op_class_t       w_class;
  logic [4:0]      w_alu_op;
  logic            w_unused_ir;

  assign w_opcode    = IR[31 -: OP_W];
  assign w_unused_ir = ^IR[31-OP_W:0];
  assign w_class     = op_class_t'(w_class_bits);

  control_sequencer_op_class u_op_class (
    .i_opcode (w_opcode),
    .o_class  (w_class_bits),
    .o_alu_op (w_alu_op)
  );

`ifdef CTRL_STEP_EN
  assign w_done_state = S_WAIT_STEP;
`else
  assign w_done_state = S_T0;
`endif

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_state    <= S_RESET;
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_bus_err  <= w_bus_err_nxt;
    end
  end

  // T1 stalls on MemReady; a ready seen while the count equals the limit still succeeds
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_bus_err_nxt  = r_bus_err;
    case (r_state)
      S_RESET: w_state_nxt = S_T0;
      S_T0: begin
        w_state_nxt    = S_T1;
        w_wait_cnt_nxt = '0;
      end
      S_T1: begin
        if (MemReady) begin
          w_state_nxt    = S_T2;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == LP_WAIT_LIMIT) begin
          w_state_nxt   = S_HALT;
          w_bus_err_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end
      S_T2: w_state_nxt = S_T3;
      S_T3: begin
        case (w_class)
          CL_NOP, CL_ILL: w_state_nxt = w_done_state;
          CL_HALT:        w_state_nxt = S_HALT;
          default:        w_state_nxt = S_T4;
        endcase
      end
      S_T4: w_state_nxt = (w_class == CL_UNARY) ? w_done_state : S_T5;
      S_T5: w_state_nxt = (w_class == CL_MULDIV) ? S_T6 : w_done_state;
      S_T6: w_state_nxt = w_done_state;
`ifdef CTRL_STEP_EN
      S_WAIT_STEP: if (Step) w_state_nxt = S_T0;
`else
      S_WAIT_STEP: w_state_nxt = S_T0;
`endif
      default: ;
    endcase
  end

  always_comb begin
    PCout     = 1'b0;
    ZHighout  = 1'b0;
    Zlowout   = 1'b0;
    MDRout    = 1'b0;
    Cout      = 1'b0;
    MARin     = 1'b0;
    PCin      = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    ZHighIn   = 1'b0;
    ZLowIn    = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    AluOp     = ALU_NOP;
    Run       = 1'b0;
    IllegalOp = 1'b0;
    case (r_state)
      S_T0: begin Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
      S_T1: begin Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin Run = 1'b1; MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        Run = 1'b1;
        case (w_class)
          CL_RRR, CL_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_UNARY:       begin Grb = 1'b1; Rout = 1'b1; AluOp = w_alu_op; ZLowIn = 1'b1; end
          CL_MULDIV:      begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_ILL:         IllegalOp = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        Run = 1'b1;
        case (w_class)
          CL_RRR:    begin Grc = 1'b1; Rout = 1'b1; AluOp = w_alu_op; ZLowIn = 1'b1; end
          CL_IMM:    begin Cout = 1'b1; AluOp = w_alu_op; ZLowIn = 1'b1; end
          CL_UNARY:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_MULDIV: begin
            Grb = 1'b1; Rout = 1'b1; AluOp = w_alu_op; ZHighIn = 1'b1; ZLowIn = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        Run = 1'b1;
        case (w_class)
          CL_RRR, CL_IMM: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_MULDIV:      begin Zlowout = 1'b1; LOin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin Run = 1'b1; ZHighout = 1'b1; HIin = 1'b1; end
      default: ;
    endcase
  end

  assign BusErr = r_bus_err;

  a_one_bus_driver: assert property (@(posedge Clock) disable iff (!Clear)
    $onehot0({PCout, ZHighout, Zlowout, MDRout, Cout, Rout}));

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer; define CTRL_STEP_EN to bench the stepping build
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  localparam logic [28:0] B_BUSERR   = 29'h1 << 0;
  localparam logic [28:0] B_ILLEGAL  = 29'h1 << 1;
  localparam logic [28:0] B_RUN      = 29'h1 << 2;
  localparam logic [28:0] B_READ     = 29'h1 << 8;
  localparam logic [28:0] B_INCPC    = 29'h1 << 9;
  localparam logic [28:0] B_ROUT     = 29'h1 << 10;
  localparam logic [28:0] B_RIN      = 29'h1 << 11;
  localparam logic [28:0] B_GRC      = 29'h1 << 12;
  localparam logic [28:0] B_GRB      = 29'h1 << 13;
  localparam logic [28:0] B_GRA      = 29'h1 << 14;
  localparam logic [28:0] B_ZLOWIN   = 29'h1 << 15;
  localparam logic [28:0] B_ZHIGHIN  = 29'h1 << 16;
  localparam logic [28:0] B_LOIN     = 29'h1 << 17;
  localparam logic [28:0] B_HIIN     = 29'h1 << 18;
  localparam logic [28:0] B_YIN      = 29'h1 << 19;
  localparam logic [28:0] B_IRIN     = 29'h1 << 20;
  localparam logic [28:0] B_MDRIN    = 29'h1 << 21;
  localparam logic [28:0] B_PCIN     = 29'h1 << 22;
  localparam logic [28:0] B_MARIN    = 29'h1 << 23;
  localparam logic [28:0] B_COUT     = 29'h1 << 24;
  localparam logic [28:0] B_MDROUT   = 29'h1 << 25;
  localparam logic [28:0] B_ZLOWOUT  = 29'h1 << 26;
  localparam logic [28:0] B_ZHIGHOUT = 29'h1 << 27;
  localparam logic [28:0] B_PCOUT    = 29'h1 << 28;

  localparam logic [28:0] W_T0 = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN;
  localparam logic [28:0] W_T1 = B_RUN | B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [28:0] W_T2 = B_RUN | B_MDROUT | B_IRIN;

  typedef struct {
    logic [28:0] w;
    string       tag;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] IR;
  logic        MemReady;
`ifdef CTRL_STEP_EN
  logic        Step = 1'b1;
`endif
  logic PCout, ZHighout, Zlowout, MDRout, Cout;
  logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn;
  logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Run, IllegalOp, BusErr;
  logic [4:0]  AluOp;
  logic [28:0] act;

  exp_t        exp_q[$];
  logic [28:0] model_q[$];
  bit          model_halt;
  bit          bus_err_m = 1'b0;
  int          checks    = 0;
  int          failures  = 0;
  logic [4:0]  legal_ops [12];

  always #5 Clock = ~Clock;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .MemReady(MemReady),
`ifdef CTRL_STEP_EN
    .Step(Step),
`endif
    .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
    .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .IncPC(IncPC), .Read(Read), .AluOp(AluOp), .Run(Run),
    .IllegalOp(IllegalOp), .BusErr(BusErr)
  );

  assign act = {PCout, ZHighout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin,
                HIin, LOin, ZHighIn, ZLowIn, Gra, Grb, Grc, Rin, Rout, IncPC, Read,
                AluOp, Run, IllegalOp, BusErr};

  always @(negedge Clock) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e.w) begin
        failures++;
        $display("FAIL %s: got %h expected %h at %0t", e.tag, act, e.w, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4:0] alu_of(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB:          return ALU_SUB;
      OP_AND:          return ALU_AND;
      OP_OR:           return ALU_OR;
      OP_SHR:          return ALU_SHR;
      OP_SHL:          return ALU_SHL;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      default:         return ALU_NOP;
    endcase
  endfunction

  // Expected execute-phase control words, one entry per cycle from T3 onward
  function automatic void exec_model(input logic [4:0] op);
    logic [28:0] a;
    a = {21'b0, alu_of(op), 3'b0};
    model_q.delete();
    model_halt = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: begin
        model_q.push_back(B_RUN | B_GRB | B_ROUT | B_YIN);
        model_q.push_back(B_RUN | B_GRC | B_ROUT | B_ZLOWIN | a);
        model_q.push_back(B_RUN | B_ZLOWOUT | B_GRA | B_RIN);
      end
      OP_ADDI: begin
        model_q.push_back(B_RUN | B_GRB | B_ROUT | B_YIN);
        model_q.push_back(B_RUN | B_COUT | B_ZLOWIN | a);
        model_q.push_back(B_RUN | B_ZLOWOUT | B_GRA | B_RIN);
      end
      OP_NEG, OP_NOT: begin
        model_q.push_back(B_RUN | B_GRB | B_ROUT | B_ZLOWIN | a);
        model_q.push_back(B_RUN | B_ZLOWOUT | B_GRA | B_RIN);
      end
      OP_MUL, OP_DIV: begin
        model_q.push_back(B_RUN | B_GRA | B_ROUT | B_YIN);
        model_q.push_back(B_RUN | B_GRB | B_ROUT | B_ZHIGHIN | B_ZLOWIN | a);
        model_q.push_back(B_RUN | B_ZLOWOUT | B_LOIN);
        model_q.push_back(B_RUN | B_ZHIGHOUT | B_HIIN);
      end
      OP_NOP:  model_q.push_back(B_RUN);
      OP_HALT: begin
        model_q.push_back(B_RUN);
        model_halt = 1'b1;
      end
      default: model_q.push_back(B_RUN | B_ILLEGAL);
    endcase
  endfunction

  task automatic cyc(input logic [31:0] ir, input logic mr, input logic [28:0] w, input string tag);
    exp_t e;
    @(posedge Clock);
    #1;
    IR       = ir;
    MemReady = mr;
    e.w      = bus_err_m ? (w | B_BUSERR) : w;
    e.tag    = tag;
    exp_q.push_back(e);
  endtask

  task automatic do_clear(input bit mid, input logic [31:0] ir);
    exp_t e;
    @(posedge Clock);
    #1;
    IR       = ir;
    MemReady = 1'($urandom);
    if (mid) #2;
    Clear     = 1'b0;
    bus_err_m = 1'b0;
    e.w       = '0;
    e.tag     = mid ? "clear_mid" : "clear";
    exp_q.push_back(e);
  endtask

  task automatic release_clear();
    exp_t e;
    @(posedge Clock);
    #1;
    Clear = 1'b1;
    e.w   = '0;
    e.tag = "reset_state";
    exp_q.push_back(e);
  endtask

  task automatic halt_cycles(input int n);
    for (int k = 0; k < n; k++) cyc($urandom, 1'($urandom), '0, "halt");
  endtask

  // nwait: T1 cycles with MemReady low before it rises (>=16 means never); abort_at: exec index to clear mid-cycle
  task automatic run_instr(input logic [31:0] ir, input int nwait, input int abort_at);
    cyc($urandom, 1'($urandom), W_T0, "T0");
    for (int k = 0; k < nwait && k < 16; k++) cyc($urandom, 1'b0, W_T1, "T1_hold");
    if (nwait >= 16) begin
      bus_err_m = 1'b1;
      return;
    end
    cyc($urandom, 1'b1, W_T1, "T1");
    cyc($urandom, 1'($urandom), W_T2, "T2");
    exec_model(ir[31:27]);
    for (int i = 0; i < model_q.size(); i++) begin
      if (i == abort_at) begin
        do_clear(1'b1, ir);
        return;
      end
      cyc(ir, 1'($urandom), model_q[i], $sformatf("op%05b_T%0d", ir[31:27], i + 3));
    end
`ifdef CTRL_STEP_EN
    if (!model_halt) cyc(ir, 1'($urandom), '0, "wait_step");
`endif
  endtask

  initial begin
    int nw;
    logic [4:0] op;
    legal_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
                  OP_NEG, OP_NOT, OP_MUL, OP_DIV, OP_ADDI, OP_NOP};
    Clear    = 1'b0;
    IR       = '0;
    MemReady = 1'b0;
    do_clear(1'b0, 32'h0);
    do_clear(1'b0, 32'h0);
    release_clear();

    run_instr(32'h1A920000, 0, -1);
    run_instr(32'h4A920000, 0, -1);
    run_instr({OP_MUL, 27'h1234567}, 0, -1);
    run_instr({OP_DIV, 27'h0ABCDEF}, 2, -1);
    run_instr({OP_ADDI, 27'h5A5A5A5}, 0, -1);
    run_instr({OP_NOT, 27'h0000011}, 1, -1);
    run_instr(32'h1A920000, 3, -1);
    run_instr({OP_SUB, 27'h7FFFFFF}, 15, -1);
    run_instr({5'b11111, 27'h0}, 0, -1);
    run_instr({OP_NOP, 27'h0}, 0, -1);

    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(0, 31));
      else op = legal_ops[$urandom_range(0, 11)];
      if (op == OP_HALT) op = 5'b11111;
      nw = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 15));
      run_instr({op, 27'($urandom)}, nw, -1);
    end

    run_instr(32'h1A920000, 0, 1);
    do_clear(1'b0, 32'h1A920000);
    release_clear();
    run_instr(32'h1A920000, 1, -1);

    run_instr({OP_AND, 27'h0123456}, 16, -1);
    halt_cycles(6);
    do_clear(1'b0, 32'h0);
    release_clear();
    run_instr(32'h1A920000, 0, -1);

    run_instr({OP_HALT, 27'h0}, 0, -1);
    halt_cycles(100);
    do_clear(1'b0, 32'h0);
    release_clear();
    run_instr(32'h4A920000, 0, -1);

    repeat (3) @(negedge Clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
